// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I control FSM with memory timeout, trap and perf counters
//
// Sequences FETCH -> DECODE -> EXEC -> [MEM] -> [WB] for each instruction and
// drives the shared-datapath select/enable lines. Memory waits are bounded by
// MEM_TIMEOUT; illegal instructions and memory timeouts park the FSM in TRAP
// until reset.
//
// Optional feature macro: CTRL_PERF_CNT_EN (cycle/instret counters; tied to 0
// and flop-free when undefined).
//
// Parameters:
//   MEM_TIMEOUT  max wait cycles for mem_ack in FETCH/MEM (0 = no timeout)
//   CNT_W        performance counter width
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   opcode, funct3, funct7_5  instruction register fields instr[6:2], [14:12], [30]
//   br_eq, br_lt              branch comparator flags (valid in EXEC)
//   mem_ack                   memory completes current request
//   pc_we, pc_sel             PC write strobe, PC source (0 PC+4, 1 ALU)
//   ir_we                     instruction register load
//   imm_sel, a_sel, b_sel     immediate format and ALU operand selects
//   alu_sel                   ALU operation
//   mem_req, mem_rw           memory request, direction (1 = write)
//   reg_wen, wb_sel           regfile write enable, writeback source
//   br_un                     unsigned branch compare
//   state, trap, trap_cause   debug state, trap flag, trap cause
//   cycle_cnt, instret_cnt    performance counters

module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             br_eq,
  input  logic             br_lt,
  input  logic             mem_ack,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             ir_we,
  output logic [2:0]       imm_sel,
  output logic             a_sel,
  output logic             b_sel,
  output logic [3:0]       alu_sel,
  output logic             mem_req,
  output logic             mem_rw,
  output logic             reg_wen,
  output logic [1:0]       wb_sel,
  output logic             br_un,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_REG    = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  localparam logic [2:0] IMM_UI   = 3'd0;
  localparam logic [2:0] IMM_LI   = 3'd1;
  localparam logic [2:0] IMM_SE05 = 3'd2;
  localparam logic [2:0] IMM_BR   = 3'd3;
  localparam logic [2:0] IMM_ST   = 3'd4;
  localparam logic [2:0] IMM_JP   = 3'd5;
  localparam logic [2:0] IMM_NONE = 3'd6;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_SLT  = 4'h2;
  localparam logic [3:0] ALU_SLTU = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_OR   = 4'h5;
  localparam logic [3:0] ALU_AND  = 4'h6;
  localparam logic [3:0] ALU_SLL  = 4'h7;
  localparam logic [3:0] ALU_SRL  = 4'h8;
  localparam logic [3:0] ALU_SRA  = 4'h9;
  localparam logic [3:0] ALU_LUI  = 4'hA;

  localparam logic [1:0] WB_PC  = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_LD  = 2'd2;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  // Counter must be able to hold MEM_TIMEOUT itself; keep at least one bit
  // so a disabled timeout still elaborates.
  localparam int              WAIT_W   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_t            state_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        cause_q;

  logic is_reg, is_imm, is_load, is_store, is_branch;
  logic is_jal, is_jalr, is_lui, is_auipc, legal;
  logic timeout_hit;

  logic [2:0] dp_imm;
  logic       dp_a, dp_b;
  logic [3:0] dp_alu;
  logic [1:0] dp_wb;
  logic       dp_br_un;
  logic       taken;

  // ---------------------------------------------------------------
  // Instruction classification
  // ---------------------------------------------------------------
  assign is_reg    = (opcode == OP_REG);
  assign is_imm    = (opcode == OP_IMM);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_lui    = (opcode == OP_LUI);
  assign is_auipc  = (opcode == OP_AUIPC);

  // Branch funct3 010/011 are unassigned encodings.
  assign legal = is_reg | is_imm | is_load | is_store | is_jal | is_jalr |
                 is_lui | is_auipc | (is_branch && (funct3[2:1] != 2'b01));

  // wait_cnt only ever reaches WAIT_MAX in FETCH/MEM.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_MAX);

  // ---------------------------------------------------------------
  // Datapath selects derived from the IR fields
  // ---------------------------------------------------------------
  always_comb begin
    dp_imm   = IMM_NONE;
    dp_a     = 1'b0;
    dp_b     = 1'b0;
    dp_alu   = ALU_ADD;
    dp_wb    = WB_ALU;
    dp_br_un = 1'b0;
    taken    = 1'b0;

    if (is_reg || is_imm) begin
      dp_b = is_imm;
      if (is_imm)
        dp_imm = ((funct3 == 3'b001) || (funct3 == 3'b101)) ? IMM_SE05 : IMM_LI;
      case (funct3)
        3'b000:  dp_alu = (is_reg && funct7_5) ? ALU_SUB : ALU_ADD; // ADDI has no SUB form
        3'b001:  dp_alu = ALU_SLL;
        3'b010:  dp_alu = ALU_SLT;
        3'b011:  dp_alu = ALU_SLTU;
        3'b100:  dp_alu = ALU_XOR;
        3'b101:  dp_alu = funct7_5 ? ALU_SRA : ALU_SRL;
        3'b110:  dp_alu = ALU_OR;
        default: dp_alu = ALU_AND;
      endcase
    end

    if (is_load) begin
      dp_imm = IMM_LI;
      dp_b   = 1'b1;
      dp_wb  = WB_LD;
    end

    if (is_store) begin
      dp_imm = IMM_ST;
      dp_b   = 1'b1;
    end

    if (is_branch) begin
      // ALU computes the target PC + imm while the comparator decides.
      dp_imm   = IMM_BR;
      dp_a     = 1'b1;
      dp_b     = 1'b1;
      dp_br_un = funct3[1];
      case (funct3)
        3'b000:         taken = br_eq;
        3'b001:         taken = !br_eq;
        3'b100, 3'b110: taken = br_lt;
        3'b101, 3'b111: taken = !br_lt;
        default:        taken = 1'b0;
      endcase
    end

    if (is_jal) begin
      dp_imm = IMM_JP;
      dp_a   = 1'b1;
      dp_b   = 1'b1;
      dp_wb  = WB_PC;
    end

    if (is_jalr) begin
      dp_imm = IMM_LI;
      dp_b   = 1'b1;
      dp_wb  = WB_PC;
    end

    if (is_lui) begin
      dp_imm = IMM_UI;
      dp_b   = 1'b1;
      dp_alu = ALU_LUI;
    end

    if (is_auipc) begin
      dp_imm = IMM_UI;
      dp_a   = 1'b1;
      dp_b   = 1'b1;
    end
  end

  // ---------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      wait_cnt <= '0;
      cause_q  <= 2'd0;
    end else begin
      case (state_q)
        S_FETCH: begin
          // mem_ack wins over a timeout in the same cycle.
          if (mem_ack) begin
            state_q  <= S_DECODE;
            wait_cnt <= '0;
          end else if (timeout_hit) begin
            state_q <= S_TRAP;
            cause_q <= CAUSE_TIMEOUT;
          end else if (MEM_TIMEOUT != 0) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        S_DECODE: begin
          wait_cnt <= '0;
          if (legal) begin
            state_q <= S_EXEC;
          end else begin
            state_q <= S_TRAP;
            cause_q <= CAUSE_ILLEGAL;
          end
        end

        S_EXEC: begin
          wait_cnt <= '0;
          if (is_branch)
            state_q <= S_FETCH;
          else if (is_load || is_store)
            state_q <= S_MEM;
          else
            state_q <= S_WB;
        end

        S_MEM: begin
          if (mem_ack) begin
            state_q  <= is_load ? S_WB : S_FETCH;
            wait_cnt <= '0;
          end else if (timeout_hit) begin
            state_q <= S_TRAP;
            cause_q <= CAUSE_TIMEOUT;
          end else if (MEM_TIMEOUT != 0) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        S_WB: begin
          wait_cnt <= '0;
          state_q  <= S_FETCH;
        end

        S_TRAP: begin
          wait_cnt <= '0;
        end

        default: begin
          wait_cnt <= '0;
          state_q  <= S_FETCH;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Control outputs
  // ---------------------------------------------------------------
  always_comb begin
    pc_we   = 1'b0;
    pc_sel  = 1'b0;
    ir_we   = 1'b0;
    mem_req = 1'b0;
    mem_rw  = 1'b0;
    reg_wen = 1'b0;
    imm_sel = IMM_NONE;
    a_sel   = 1'b0;
    b_sel   = 1'b0;
    alu_sel = ALU_ADD;
    wb_sel  = WB_ALU;
    br_un   = 1'b0;

    // Selects are held from DECODE through WB so the ALU result stays
    // stable for the PC/regfile writes at the end of the instruction.
    if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      imm_sel = dp_imm;
      a_sel   = dp_a;
      b_sel   = dp_b;
      alu_sel = dp_alu;
      wb_sel  = dp_wb;
      br_un   = dp_br_un;
    end

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ack;
      end
      S_EXEC: begin
        if (is_branch) begin
          pc_we  = 1'b1;
          pc_sel = taken;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_rw  = is_store;
        pc_we   = is_store && mem_ack;
      end
      S_WB: begin
        reg_wen = 1'b1;
        pc_we   = 1'b1;
        pc_sel  = is_jal || is_jalr;
      end
      default: begin
      end
    endcase

    // Reset aborts the instruction: no side effects while rst is high.
    if (rst) begin
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      mem_req = 1'b0;
      reg_wen = 1'b0;
    end
  end

  assign state      = state_q;
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;

  // ---------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------
`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (pc_we)
        instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl

module tb_multicycle_ctrl;

  localparam int TO    = 4;
  localparam int CNT_W = 4;

  localparam logic [4:0] OP_LOAD = 5'b00000, OP_IMM = 5'b00100, OP_AUIPC = 5'b00101,
                         OP_STORE = 5'b01000, OP_REG = 5'b01100, OP_LUI = 5'b01101,
                         OP_BR = 5'b11000, OP_JALR = 5'b11001, OP_JAL = 5'b11011,
                         OP_BAD = 5'b11111;

  localparam logic [2:0] S_FETCH = 0, S_DECODE = 1, S_EXEC = 2, S_MEM = 3, S_WB = 4, S_TRAP = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic funct7_5 = 1'b0, br_eq = 1'b0, br_lt = 1'b0, mem_ack = 1'b0;
  logic pc_we, pc_sel, ir_we, a_sel, b_sel, mem_req, mem_rw, reg_wen, br_un, trap;
  logic [2:0] imm_sel, state;
  logic [3:0] alu_sel;
  logic [1:0] wb_sel, trap_cause;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .br_eq(br_eq), .br_lt(br_lt), .mem_ack(mem_ack),
    .pc_we(pc_we), .pc_sel(pc_sel), .ir_we(ir_we), .imm_sel(imm_sel),
    .a_sel(a_sel), .b_sel(b_sel), .alu_sel(alu_sel), .mem_req(mem_req),
    .mem_rw(mem_rw), .reg_wen(reg_wen), .wb_sel(wb_sel), .br_un(br_un),
    .state(state), .trap(trap), .trap_cause(trap_cause),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic       pc_we, pc_sel, ir_we, mem_req, mem_rw, reg_wen, br_un;
    logic [1:0] wb_sel, cause;
    logic [3:0] alu;
    bit         chk_pcsel, chk_wb, chk_alu, chk_brun, chk_memrw, rst1, rst2;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [1:0] exp_cause = 2'd0;
  bit   noise = 1'b0;
  int   cyc_m = 0;
  int   ret_m = 0;
  int   n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the instruction rules ----------------
  function automatic bit is_legal(input logic [4:0] op, input logic [2:0] f3);
    if (op == OP_BR) return !(f3 == 3'b010 || f3 == 3'b011);
    return op inside {OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  endfunction

  function automatic logic [3:0] alu_of(input logic [4:0] op, input logic [2:0] f3, input logic f7);
    logic [3:0] tbl [8];
    tbl = '{4'h0, 4'h7, 4'h2, 4'h3, 4'h4, 4'h8, 4'h5, 4'h6};
    if (op == OP_LUI) return 4'hA;
    if (op != OP_REG && op != OP_IMM) return 4'h0;
    if (f3 == 3'b000 && op == OP_REG && f7) return 4'h1;
    if (f3 == 3'b101 && f7) return 4'h9;
    return tbl[f3];
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic eq, input logic lt);
    case (f3)
      3'b000: return eq;
      3'b001: return !eq;
      3'b100, 3'b110: return lt;
      default: return !lt;
    endcase
  endfunction

  function automatic logic [31:0] cnt_exp(input int v);
`ifdef CTRL_PERF_CNT_EN
    return v % (1 << CNT_W);
`else
    return (v > 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  function automatic exp_t mk(input logic [2:0] st);
    exp_t e;
    e.st = st; e.pc_we = 0; e.pc_sel = 0; e.ir_we = 0; e.mem_req = 0; e.mem_rw = 0;
    e.reg_wen = 0; e.br_un = 0; e.wb_sel = 0; e.alu = 0; e.cause = exp_cause;
    e.chk_pcsel = 0; e.chk_wb = 0; e.chk_alu = 0; e.chk_brun = 0; e.chk_memrw = 0;
    e.rst1 = 0; e.rst2 = 0;
    return e;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("pc_we", pc_we, e.pc_we);
      chk("ir_we", ir_we, e.ir_we);
      chk("mem_req", mem_req, e.mem_req);
      chk("reg_wen", reg_wen, e.reg_wen);
      if (e.rst1) begin
        cyc_m = 0;
        ret_m = 0;
      end else begin
        chk("state", state, e.st);
        chk("trap", trap, e.st == S_TRAP);
        chk("trap_cause", trap_cause, e.cause);
        if (e.chk_memrw) chk("mem_rw", mem_rw, e.mem_rw);
        if (e.chk_pcsel) chk("pc_sel", pc_sel, e.pc_sel);
        if (e.chk_wb)    chk("wb_sel", wb_sel, e.wb_sel);
        if (e.chk_alu)   chk("alu_sel", alu_sel, e.alu);
        if (e.chk_brun)  chk("br_un", br_un, e.br_un);
        chk("cycle_cnt", cycle_cnt, cnt_exp(cyc_m));
        chk("instret_cnt", instret_cnt, cnt_exp(ret_m));
        if (!e.rst2) begin
          cyc_m++;
          ret_m += int'(e.pc_we);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    exp_t e;
    rst = 1'b1;
    mem_ack = 1'b1;           // must not leak through while in reset
    e = mk(S_FETCH); e.rst1 = 1; q.push_back(e); step();
    exp_cause = 2'd0;
    e = mk(S_FETCH); e.rst2 = 1; q.push_back(e); step();
    rst = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic trap_idle(input int cyc);
    for (int i = 0; i < cyc; i++) begin
      mem_ack = i[0];
      q.push_back(mk(S_TRAP));
      step();
    end
  endtask

  // Runs one instruction; fw/mw = wait cycles before mem_ack in FETCH/MEM,
  // abort = cycle count after which the task returns early (0 = never).
  task automatic run_instr(input logic [4:0] op, input logic [2:0] f3, input logic f7,
                           input logic eq, input logic lt, input int fw, input int mw,
                           input int abort, output int ncyc);
    exp_t e;
    bit   rr;
    ncyc = 0;
    opcode = op; funct3 = f3; funct7_5 = f7; br_eq = eq; br_lt = lt;
    noise = ~noise;
    rr = (op == OP_REG || op == OP_IMM);
    for (int i = 0; ; i++) begin
      e = mk(S_FETCH); e.mem_req = 1; e.chk_memrw = 1;
      if (i == fw) begin
        mem_ack = 1'b1; e.ir_we = 1; q.push_back(e); step(); ncyc++;
        break;
      end
      mem_ack = 1'b0; q.push_back(e); step(); ncyc++;
      if (i == TO) begin exp_cause = 2'd2; return; end
    end
    mem_ack = noise;
    q.push_back(mk(S_DECODE)); step(); ncyc++;
    if (ncyc == abort) return;
    if (!is_legal(op, f3)) begin exp_cause = 2'd1; return; end

    e = mk(S_EXEC);
    e.alu = alu_of(op, f3, f7);
    e.chk_alu = rr || op inside {OP_LOAD, OP_STORE, OP_LUI};
    if (op == OP_BR) begin
      e.pc_we = 1; e.pc_sel = br_taken(f3, eq, lt); e.chk_pcsel = 1;
      e.br_un = f3[1]; e.chk_brun = 1;
    end
    q.push_back(e); step(); ncyc++;
    if (ncyc == abort) return;
    if (op == OP_BR) return;

    if (op == OP_LOAD || op == OP_STORE) begin
      for (int i = 0; ; i++) begin
        e = mk(S_MEM); e.mem_req = 1; e.mem_rw = (op == OP_STORE); e.chk_memrw = 1;
        if (i == mw) begin
          mem_ack = 1'b1;
          if (op == OP_STORE) begin e.pc_we = 1; e.pc_sel = 0; e.chk_pcsel = 1; end
          q.push_back(e); step(); ncyc++;
          break;
        end
        mem_ack = 1'b0; q.push_back(e); step(); ncyc++;
        if (i == TO) begin exp_cause = 2'd2; return; end
      end
      if (op == OP_STORE) return;
    end

    mem_ack = noise;
    e = mk(S_WB); e.reg_wen = 1; e.pc_we = 1;
    e.pc_sel = (op == OP_JAL || op == OP_JALR); e.chk_pcsel = 1;
    e.wb_sel = (op == OP_JAL || op == OP_JALR) ? 2'd0 : (op == OP_LOAD) ? 2'd2 : 2'd1;
    e.chk_wb = 1;
    e.alu = alu_of(op, f3, f7); e.chk_alu = rr;
    q.push_back(e); step(); ncyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    run_instr(OP_REG, 3'b000, 1'b0, 0, 0, 0, 0, 0, n); chk("len_add", n, 4);
    run_instr(OP_REG, 3'b000, 1'b1, 0, 0, 0, 0, 0, n);          // SUB
    run_instr(OP_IMM, 3'b000, 1'b1, 0, 0, 1, 0, 0, n);          // ADDI ignores funct7_5
    run_instr(OP_IMM, 3'b101, 1'b1, 0, 0, 0, 0, 0, n);          // SRAI
    run_instr(OP_IMM, 3'b011, 1'b0, 0, 0, 0, 0, 0, n);          // SLTIU
    run_instr(OP_REG, 3'b111, 1'b0, 0, 0, 0, 0, 0, n);          // AND
    run_instr(OP_LUI, 3'b000, 1'b0, 0, 0, 0, 0, 0, n);
    run_instr(OP_AUIPC, 3'b000, 1'b0, 0, 0, 0, 0, 0, n);
    run_instr(OP_JAL, 3'b000, 1'b0, 0, 0, 0, 0, 0, n); chk("len_jal", n, 4);
    run_instr(OP_JALR, 3'b000, 1'b0, 0, 0, 2, 0, 0, n); chk("len_jalr_wait2", n, 6);
    run_instr(OP_BR, 3'b111, 1'b0, 0, 0, 0, 0, 0, n); chk("len_bgeu", n, 3);
    run_instr(OP_BR, 3'b111, 1'b0, 0, 1, 0, 0, 0, n);           // BGEU not taken
    run_instr(OP_BR, 3'b000, 1'b0, 1, 0, 0, 0, 0, n);           // BEQ taken
    run_instr(OP_BR, 3'b001, 1'b0, 1, 0, 0, 0, 0, n);           // BNE not taken
    run_instr(OP_BR, 3'b100, 1'b0, 0, 1, 0, 0, 0, n);           // BLT taken
    run_instr(OP_LOAD, 3'b010, 1'b0, 0, 0, 0, 3, 0, n); chk("len_lw_wait3", n, 8);
    run_instr(OP_LOAD, 3'b010, 1'b0, 0, 0, 0, 0, 0, n); chk("len_lw", n, 5);
    run_instr(OP_STORE, 3'b010, 1'b0, 0, 0, 0, 0, 0, n); chk("len_sw", n, 4);
    run_instr(OP_STORE, 3'b010, 1'b0, 0, 0, 1, TO, 0, n);       // MEM ack exactly at limit
    run_instr(OP_REG, 3'b000, 1'b0, 0, 0, TO, 0, 0, n); chk("len_fetch_at_limit", n, 4 + TO);

    // Performance counters: 10 ADDs from reset, then 6 more to wrap a 4-bit counter
    do_reset();
    for (int i = 0; i < 10; i++) run_instr(OP_REG, 3'b000, 1'b0, 0, 0, 0, 0, 0, n);
`ifdef CTRL_PERF_CNT_EN
    chk("cycle_cnt_10add", cycle_cnt, 32'd8);      // 40 mod 16
    chk("instret_cnt_10add", instret_cnt, 32'd10);
`else
    chk("cycle_cnt_off", cycle_cnt, 32'd0);
    chk("instret_cnt_off", instret_cnt, 32'd0);
`endif
    for (int i = 0; i < 6; i++) run_instr(OP_REG, 3'b000, 1'b0, 0, 0, 0, 0, 0, n);
    chk("cycle_cnt_wrap", cycle_cnt, 32'd0);       // 64 mod 16
    chk("instret_cnt_wrap", instret_cnt, 32'd0);   // 16 mod 16

    // FETCH timeout
    run_instr(OP_REG, 3'b000, 1'b0, 0, 0, TO + 3, 0, 0, n);
    chk("len_fetch_timeout", n, TO + 1);
    trap_idle(5);
    chk("trap_cause_timeout", trap_cause, 32'd2);
    chk("trap_flag", trap, 32'd1);
    do_reset();
    chk("state_after_rst", state, 32'd0);

    // Illegal opcode and illegal branch funct3
    run_instr(OP_BAD, 3'b000, 1'b0, 0, 0, 0, 0, 0, n);
    trap_idle(3);
    chk("trap_cause_illegal", trap_cause, 32'd1);
    do_reset();
    run_instr(OP_BR, 3'b010, 1'b0, 0, 0, 0, 0, 0, n);
    trap_idle(3);
    do_reset();

    // MEM timeout on a load
    run_instr(OP_LOAD, 3'b010, 1'b0, 0, 0, 0, 20, 0, n);
    trap_idle(2);
    do_reset();

    // Reset lands in WB: no writeback strobes may escape
    run_instr(OP_REG, 3'b000, 1'b0, 0, 0, 0, 0, 3, n);
    do_reset();
    run_instr(OP_REG, 3'b100, 1'b0, 0, 0, 0, 0, 0, n);

    step();
    chk("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle RV32I control unit: a state machine that sequences FETCH, DECODE, EXEC, MEM and WB for each instruction and drives the datapath select and enable lines. It sits between the instruction register and the shared datapath (regfile, ALU, branch comparator, single memory port). It adds three things a single-cycle decoder does not have:
- a memory handshake with timeout,
- a trap state,
- optional performance counters.

## Interface
- `MEM_TIMEOUT`, 16: maximum wait cycles for `mem_ack` in FETCH or MEM; 0 disables the timeout.
- `CNT_W`, 32: width of the performance counters.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `opcode` in 5: `instr[6:2]` from the instruction register.
- `funct3` in 3: `instr[14:12]`.
- `funct7_5` in 1: `instr[30]`.
- `br_eq`, `br_lt` in 1: comparator flags, valid during EXEC.
- `mem_ack` in 1: memory completes the current request.
- `pc_we` in… `pc_we` out 1: PC write strobe.
- `pc_sel` out 1: 0 = PC+4, 1 = ALU out.
- `ir_we` out 1: load the instruction register.
- `imm_sel` out 3: immediate format. UI = 0, LI = 1, SE05 = 2, BR = 3, ST = 4, JP = 5, NONE = 6.
- `a_sel`, `b_sel` out 1: 0 = register, 1 = PC or immediate.
- `alu_sel` out 4: ALU operation. ADD = 0, SUB = 1, SLT = 2, SLTU = 3, XOR = 4, OR = 5, AND = 6, SLL = 7, SRL = 8, SRA = 9, LUI = A.
- `mem_req` out 1: memory request.
- `mem_rw` out 1: 0 = read, 1 = write.
- `reg_wen` out 1: register file write enable.
- `wb_sel` out 2: PC = 0, ALU = 1, LD_DATA = 2.
- `br_un` out 1: 1 = unsigned compare.
- `state` out 3: current state, for debug.
- `trap` out 1: the FSM is in TRAP.
- `trap_cause` out 2: 1 = illegal instruction, 2 = memory timeout.
- `cycle_cnt`, `instret_cnt` out `CNT_W`: performance counters.

## Operation
- State encodings:
  - FETCH = 0
  - DECODE = 1
  - EXEC = 2
  - MEM = 3
  - WB = 4
  - TRAP = 5
- **FETCH**
  - `mem_req` = 1, `mem_rw` = 0.
  - On `mem_ack`: `ir_we` = 1, then go to DECODE.
- **DECODE**
  - Validate `opcode` and `funct3`.
  - Legal opcodes: R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - Illegal cases: any other opcode, and branch `funct3` of 010 or 011. These go to TRAP with cause 1.
  - All legal instructions go to EXEC.
- **EXEC**
  - R-type and I-type: `funct3` and `funct7_5` select `alu_sel`. ADD/SUB is chosen by `funct7_5` for R-type only. SRL/SRA is chosen by `funct7_5` for both R-type and I-type. SLTU/SLTIU use SLTU.
  - BRANCH:
    - `br_un` = 1 for BLTU/BGEU.
    - Taken conditions: BEQ = `br_eq`, BNE = !`br_eq`, BLT/BLTU = `br_lt`, BGE/BGEU = !`br_lt`.
    - `pc_we` = 1. `pc_sel` = 1 if taken, else 0.
    - Next state FETCH.
  - LOAD and STORE: ALU ADD with immediate LI or ST; next state MEM.
  - All other instructions: next state WB.
- **MEM**
  - `mem_req` = 1; `mem_rw` = 1 for STORE.
  - On `mem_ack`:
    - LOAD goes to WB.
    - STORE asserts `pc_we` = 1 with `pc_sel` = 0, then goes to FETCH.
- **WB**
  - `reg_wen` = 1 and `pc_we` = 1.
  - `wb_sel`: PC for JAL/JALR, LD_DATA for LOAD, ALU otherwise.
  - `pc_sel` = 1 for JAL/JALR, else 0.
  - Next state FETCH.
- **TRAP**
  - All strobes are 0. The FSM stays in TRAP until `rst`.
  - `trap` = 1; `trap_cause` is held.
- **Outputs in general**
  - Outputs are combinational from `state` and the IR fields.
  - Strobes (`pc_we`, `ir_we`, `mem_req`, `reg_wen`) are 0 in every state not listed above for them.
- **Timeout**
  - A wait counter of width `$clog2(MEM_TIMEOUT+1)` clears on entry to FETCH or MEM and increments on each cycle without `mem_ack`.
  - When it reaches `MEM_TIMEOUT` without `mem_ack`, go to TRAP with cause 2.
  - `mem_ack` in that same cycle wins over the timeout.
- `inst_vld` is not a port. Illegal decode is reported only via `trap`.

## Timing
- Reset, in the cycle `rst` is high:
  - `state` = FETCH, wait counter = 0, `trap` = 0, `trap_cause` = 0, counters = 0.
  - All strobes are held at 0 while `rst` is high.
- Reset mid-operation aborts the instruction; no strobes are issued.
- Cycle count per instruction, with `mem_ack` arriving in the first request cycle:
  - Branch: 3
  - ALU, LUI, AUIPC, JAL, JALR: 4
  - Store: 4
  - Load: 5
- Each memory wait cycle adds 1.
- `mem_ack` is sampled only while `mem_req` = 1; `mem_ack` outside a request is ignored.
- Exactly one `pc_we` pulse per retired instruction.

## Configuration
- `CTRL_PERF_CNT_EN` defined:
  - `cycle_cnt` increments every non-reset cycle, including cycles in TRAP.
  - `instret_cnt` increments on each `pc_we` pulse.
  - Both counters wrap modulo 2^`CNT_W`.
- `CTRL_PERF_CNT_EN` undefined:
  - Both counters are tied to 0 and no counter flops are generated.
  - All other behaviour is identical.

## Test plan
- ADD (opcode 01100, `funct3` 000, `funct7_5` 0), `mem_ack` immediate -> states 0,1,2,4,0; in WB `reg_wen` = 1, `wb_sel` = 1, `alu_sel` = 0, `pc_we` = 1, `pc_sel` = 0.
- BGEU (`funct3` 111) with `br_lt` = 0 -> in EXEC `br_un` = 1, `pc_sel` = 1, `pc_we` = 1; back to FETCH after 3 cycles. Repeat with `br_lt` = 1 -> `pc_sel` = 0.
- LW with `mem_ack` delayed 3 cycles in MEM -> `mem_req` held for 4 cycles; then WB with `wb_sel` = 2; 8 cycles total.
- `MEM_TIMEOUT` = 4, no `mem_ack` in FETCH -> TRAP after 4 wait cycles, `trap_cause` = 2; stays in TRAP until `rst`, then `state` = 0.
- Opcode 11111 -> TRAP from DECODE with `trap_cause` = 1. Branch with `funct3` 010 also traps with cause 1.
- With `CTRL_PERF_CNT_EN`: 10 ADDs -> `instret_cnt` = 10 and `cycle_cnt` = 40. Preload `CNT_W` = 4 to check wrap from 15 to 0.
